fft_reorder: RTL and testbench
==============================

# fft_reorder

Bit-reversal output reorder buffer for the 32-point MDC FFT. The FFT's final stage emits each frame of N complex samples in bit-reversed index order, and this block writes them into a ping-pong sample memory. It then reads each frame back in natural order 0..N-1 as a burst of N consecutive cycles. It sits between the last butterfly/shift stage and the FFT output port. It is the reader counterpart of the delay/shift buffers used inside the pipeline.

## Interface
- N, 32, FFT size; power of two, ≥ 4; LOG2N = log2(N) derived internally
- WIDTH, 9, bit width of each real/imag sample
- clk  in  1  master clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- di_en  in  1  input sample valid; frames may have gaps
- di_re  in  WIDTH  input sample, real part, bit-reversed order
- di_im  in  WIDTH  input sample, imag part, bit-reversed order
- do_en  out  1  output sample valid
- do_re  out  WIDTH  output sample, real part, natural order
- do_im  out  WIDTH  output sample, imag part, natural order

One clock; reset is asynchronous and active-low on rst_n.

## Operation
- Storage: two banks of N×(2·WIDTH) each. Bank memory is not reset.
- Write side
  - LOG2N-bit counter wcnt and 1-bit bank pointer wbank.
  - On each clk edge with di_en=1, store {di_re, di_im} at bank wbank, address bitrev(wcnt). bitrev reverses all LOG2N bits; for N=32, wcnt=1 → addr 16 and wcnt=3 → addr 24.
  - wcnt increments modulo N.
  - When wcnt wraps from N-1 to 0: toggle wbank and set the frame-ready event for the just-filled bank.
- Read side, FSM with states IDLE and READ:
  - IDLE → READ on the frame-ready event. rbank is latched to the just-filled bank and rcnt=0.
  - In READ, one sample per cycle at address rcnt of rbank; rcnt increments.
  - At rcnt=N-1: if another frame-ready event occurs on the same edge, stay in READ, toggle rbank, and set rcnt=0. Otherwise go to IDLE.
- Output register: do_en, do_re and do_im are registered. do_re and do_im are forced to 0 whenever do_en=0.
- No overrun by construction. At most one input per cycle means a bank needs ≥ N cycles to refill, which is ≥ the N-cycle read of the other bank. No back-pressure port exists.
- Reset (asynchronous, any time)
  - Clears wcnt, wbank, rcnt, rbank, FSM to IDLE, do_en, do_re and do_im.
  - A partial input frame is discarded.
  - A burst in progress is aborted immediately.
  - The first di_en after rst_n deasserts is sample 0 of a new frame.

## Timing
- Reset values: do_en=0, do_re=0, do_im=0.
- Latency: the last input sample of a frame (wcnt=N-1) is captured at edge E. Natural index 0 is on do_* with do_en=1 after edge E+2. Indices 1..N-1 follow on consecutive cycles with no gaps.
- Back-to-back input frames (di_en held high): do_en stays high continuously. Frame f+1 index 0 directly follows frame f index N-1.
- Gapped input: gaps only delay the frame-ready event. The output burst is always N contiguous cycles.
- Simultaneous events
  - A write into bank wbank on the same edge as a read from rbank is legal; the banks always differ in that case.
  - A frame-ready event on the final read edge chains the next burst without a bubble.

## Test plan
- **Reset:** assert rst_n=0 mid-simulation → do_en=0, do_re=0 and do_im=0 immediately, independent of clk.
- **Single frame:** N=32. Drive di_re=bitrev(k) and di_im=~bitrev(k) for k=0..31 contiguously. Response: do_en is high for exactly 32 cycles starting 2 edges after the last input, with do_re=0,1,…,31 and do_im equal to the complement of each. do_en then returns to 0.
- **Back-to-back:** three contiguous frames with distinct offsets of 0, 32 and 64, masked to WIDTH → do_en high for 96 consecutive cycles, with all samples in natural order and no bubbles.
- **Gapped input:** di_en toggling 1,0,0,1,… across a frame → output identical to the single-frame case. The burst starts 2 edges after the 32nd valid input.
- **Mid-frame reset:** reset after 17 inputs, then send a full frame with values 100+bitrev(k) → only the 32-sample burst 100..131 appears; no stale data is output.
- **Mid-burst reset:** reset during output index 10 → do_en drops at once. A subsequent frame reads out correctly from index 0.

Source files
------------

// File: rtl/fft_reorder.sv
// rtl/fft_reorder.sv - ping-pong bit-reversal to natural-order output reorder buffer
module fft_reorder #(
    parameter int N     = 32,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             di_en,
    input  logic [WIDTH-1:0] di_re,
    input  logic [WIDTH-1:0] di_im,
    output logic             do_en,
    output logic [WIDTH-1:0] do_re,
    output logic [WIDTH-1:0] do_im
);

    localparam int LOG2N = $clog2(N);
    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    typedef enum logic {S_IDLE, S_READ} state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = v[LOG2N-1-i];
        end
        return r;
    endfunction

    logic [2*WIDTH-1:0] mem_q [0:1][0:N-1];

    state_t           state_q, state_d;
    logic [LOG2N-1:0] wcnt_q, wcnt_d;
    logic [LOG2N-1:0] rcnt_q, rcnt_d;
    logic             wbank_q, wbank_d;
    logic             rbank_q, rbank_d;
    logic             rdy_q, rdy_d;
    logic             rdy_bank_q, rdy_bank_d;
    logic             do_en_q, do_en_d;
    logic [WIDTH-1:0] do_re_q, do_re_d;
    logic [WIDTH-1:0] do_im_q, do_im_d;

    // Sample memory carries no reset; a stale bank is never read before it is refilled.
    always_ff @(posedge clk) begin
        if (di_en) begin
            mem_q[wbank_q][bitrev(wcnt_q)] <= {di_re, di_im};
        end
    end

    always_comb begin
        wcnt_d     = wcnt_q;
        wbank_d    = wbank_q;
        rdy_d      = 1'b0;
        rdy_bank_d = rdy_bank_q;
        if (di_en) begin
            wcnt_d = wcnt_q + LOG2N'(1);
            if (wcnt_q == LAST) begin
                wbank_d    = ~wbank_q;
                rdy_d      = 1'b1;
                rdy_bank_d = wbank_q;
            end
        end
    end

    // The registered frame-ready pulse gives the two-edge latency and lands exactly on
    // the final read edge when frames arrive back to back.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rbank_d = rbank_q;
        do_en_d = 1'b0;
        do_re_d = '0;
        do_im_d = '0;
        case (state_q)
            S_IDLE: begin
                if (rdy_q) begin
                    state_d = S_READ;
                    rbank_d = rdy_bank_q;
                    rcnt_d  = '0;
                end
            end
            S_READ: begin
                do_en_d            = 1'b1;
                {do_re_d, do_im_d} = mem_q[rbank_q][rcnt_q];
                rcnt_d             = rcnt_q + LOG2N'(1);
                if (rcnt_q == LAST) begin
                    if (rdy_q) begin
                        rbank_d = ~rbank_q;
                        rcnt_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            wbank_q    <= 1'b0;
            rbank_q    <= 1'b0;
            rdy_q      <= 1'b0;
            rdy_bank_q <= 1'b0;
            do_en_q    <= 1'b0;
            do_re_q    <= '0;
            do_im_q    <= '0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            wbank_q    <= wbank_d;
            rbank_q    <= rbank_d;
            rdy_q      <= rdy_d;
            rdy_bank_q <= rdy_bank_d;
            do_en_q    <= do_en_d;
            do_re_q    <= do_re_d;
            do_im_q    <= do_im_d;
        end
    end

    assign do_en = do_en_q;
    assign do_re = do_re_q;
    assign do_im = do_im_q;

endmodule

// File: tb/tb_fft_reorder.sv
// tb/tb_fft_reorder.sv - directed self-checking bench for fft_reorder
module tb_fft_reorder;

    localparam int N    = 32;
    localparam int W    = 9;
    localparam int MASK = (1 << W) - 1;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         di_en = 1'b0;
    logic [W-1:0] di_re = '0;
    logic [W-1:0] di_im = '0;
    logic         do_en;
    logic [W-1:0] do_re;
    logic [W-1:0] do_im;

    fft_reorder #(.N(N), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .di_en (di_en),
        .di_re (di_re),
        .di_im (di_im),
        .do_en (do_en),
        .do_re (do_re),
        .do_im (do_im)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int q_re[$];
    int q_im[$];
    int q_cyc[$];
    int zero_viol = 0;

    always @(negedge clk) begin
        if (do_en === 1'b1) begin
            q_re.push_back(int'(do_re));
            q_im.push_back(int'(do_im));
            q_cyc.push_back(cyc);
        end else if (do_re !== '0 || do_im !== '0) begin
            zero_viol++;
        end
    end

    int checks = 0;
    int errors = 0;
    int last_edge = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int brev(input int k);
        int r = 0;
        for (int b = 0; b < 5; b++) begin
            if (((k >> b) & 1) == 1) r = r | (1 << (4 - b));
        end
        return r;
    endfunction

    task automatic send(input int base, input int count, input bit gap);
        for (int k = 0; k < count; k++) begin
            @(negedge clk);
            di_en     = 1'b1;
            di_re     = W'((base + brev(k)) & MASK);
            di_im     = W'((~(base + brev(k))) & MASK);
            last_edge = cyc + 1;
            if (gap) begin
                @(negedge clk);
                di_en = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        di_en = 1'b0;
        di_re = '0;
        di_im = '0;
    endtask

    task automatic clear_q();
        q_re.delete();
        q_im.delete();
        q_cyc.delete();
    endtask

    task automatic expect_burst(input string tag, input int base, input int count, input int start);
        check({tag, " len"}, q_re.size(), count);
        for (int i = 0; i < count && i < q_re.size(); i++) begin
            check($sformatf("%s re[%0d]", tag, i), q_re[i], (base + i) & MASK);
            check($sformatf("%s im[%0d]", tag, i), q_im[i], (~(base + i)) & MASK);
            check($sformatf("%s cyc[%0d]", tag, i), q_cyc[i], start + i);
        end
    endtask

    initial begin
        int start;
        int t;

        #1;
        check("rst do_en", do_en, 0);
        check("rst do_re", do_re, 0);
        check("rst do_im", do_im, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single contiguous frame
        clear_q();
        send(0, 32, 1'b0);
        idle();
        repeat (40) @(negedge clk);
        expect_burst("single", 0, 32, last_edge + 2);

        // three frames back to back
        clear_q();
        send(0, 32, 1'b0);
        start = last_edge + 2;
        send(32, 32, 1'b0);
        send(64, 32, 1'b0);
        idle();
        repeat (110) @(negedge clk);
        expect_burst("b2b", 0, 96, start);

        // gapped input 1,0,0,1,...
        clear_q();
        send(0, 32, 1'b1);
        idle();
        repeat (40) @(negedge clk);
        expect_burst("gap", 0, 32, last_edge + 2);

        // reset after a partial frame
        clear_q();
        send(0, 17, 1'b0);
        idle();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mf rst do_en", do_en, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(100, 32, 1'b0);
        idle();
        repeat (40) @(negedge clk);
        expect_burst("midframe", 100, 32, last_edge + 2);

        // reset while index 10 is on the output
        clear_q();
        send(0, 32, 1'b0);
        idle();
        t = 0;
        while (!(do_en === 1'b1 && do_re === W'(10)) && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("mb idx10 seen", (t < 100), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mb do_en", do_en, 0);
        check("mb do_re", do_re, 0);
        check("mb do_im", do_im, 0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_q();
        repeat (5) @(negedge clk);
        check("mb no stray", q_re.size(), 0);
        send(200, 32, 1'b0);
        idle();
        repeat (40) @(negedge clk);
        expect_burst("after_mb", 200, 32, last_edge + 2);

        check("idle outputs zero", zero_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
